// File: rtl/pl_ctrl_pkg.sv
// Shared types and constants for the pipelined RV32I control unit.
// Opcodes, ALU control codes, immediate/result selects and the per-stage control bundle.
package pl_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_ctrl_e;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      alu_ctrl_e  alu_ctrl;
      logic       alu_src_b;
      logic       alu_src_a_pc;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic [2:0] funct3;
   } ctrl_bundle_t;

   // Branch condition from funct3 and the ALU compare flags; 010/011 never reach here legally.
   function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
      logic c;
      case (f3)
         3'b000:  c = zero;
         3'b001:  c = !zero;
         3'b100:  c = lt;
         3'b101:  c = !lt;
         3'b110:  c = ltu;
         3'b111:  c = !ltu;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pl_ctrl_decoder.sv
// Purely combinational ID-stage decode of opcode/funct3/funct7[5] into a control bundle.
// Illegal encodings produce an all-zero (invalid) bundle so they travel down the pipe as bubbles.
module pl_ctrl_decoder
   import pl_ctrl_pkg::*;
(
   input  logic [6:0]   i_opcode,
   input  logic [2:0]   i_funct3,
   input  logic         i_funct7b5,
   output ctrl_bundle_t o_ctrl,
   output logic [2:0]   o_imm_src,
   output logic         o_illegal
);

   ctrl_bundle_t w_ctrl;
   logic [2:0]   w_imm_src;
   logic         w_illegal;

   function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic f7b5,
                                        input logic allow_sub);
      alu_ctrl_e op;
      case (f3)
         3'b000: op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: op = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110: op = ALU_OR;
         3'b111: op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   always_comb begin
      w_ctrl    = '0;
      w_imm_src = IMM_I;
      w_illegal = 1'b0;
      case (i_opcode)
         OP_R: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_ctrl  = alu_op(i_funct3, i_funct7b5, 1'b1);
         end
         OP_I: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_src_b = 1'b1;
            w_ctrl.alu_ctrl  = alu_op(i_funct3, i_funct7b5, 1'b0);
         end
         OP_LOAD: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.result_src = RES_MEM;
            w_ctrl.alu_src_b  = 1'b1;
            w_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
         end
         OP_STORE: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.alu_src_b = 1'b1;
            w_imm_src        = IMM_S;
            w_illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
         end
         OP_BRANCH: begin
            w_ctrl.branch   = 1'b1;
            w_ctrl.alu_ctrl = ALU_SUB;
            w_imm_src       = IMM_B;
            w_illegal = (i_funct3[2:1] == 2'b01);
         end
         OP_JAL: begin
            w_ctrl.reg_write    = 1'b1;
            w_ctrl.result_src   = RES_PC4;
            w_ctrl.jal          = 1'b1;
            w_ctrl.alu_src_a_pc = 1'b1;
            w_ctrl.alu_src_b    = 1'b1;
            w_imm_src           = IMM_J;
         end
         OP_JALR: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.result_src = RES_PC4;
            w_ctrl.jalr       = 1'b1;
            w_ctrl.alu_src_b  = 1'b1;
            w_illegal = (i_funct3 != 3'b000);
         end
         OP_LUI: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_ctrl  = ALU_PASSB;
            w_ctrl.alu_src_b = 1'b1;
            w_imm_src        = IMM_U;
         end
         OP_AUIPC: begin
            w_ctrl.reg_write    = 1'b1;
            w_ctrl.alu_src_a_pc = 1'b1;
            w_ctrl.alu_src_b    = 1'b1;
            w_imm_src           = IMM_U;
         end
         default: w_illegal = 1'b1;
      endcase
      w_ctrl.valid  = 1'b1;
      w_ctrl.funct3 = i_funct3;
      if (w_illegal) begin
         w_ctrl = '0;
      end
   end

   assign o_ctrl    = w_ctrl;
   assign o_imm_src = w_imm_src;
   assign o_illegal = w_illegal;

endmodule

// File: rtl/pl_ctrl_pipe.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers and branch resolution.
// Optional performance counters are enabled by defining PL_CTRL_PERF_EN.
module pl_ctrl_pipe #(
   parameter int ALU_CTRL_W    = 4,
   parameter int BRANCH_IN_MEM = 0,
   parameter int PERF_CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            opcode_d,
   input  logic [2:0]            funct3_d,
   input  logic                  funct7b5_d,
   input  logic                  stall_i,
   input  logic                  flush_ext_i,
   input  logic                  zero_i,
   input  logic                  lt_i,
   input  logic                  ltu_i,
   output logic [2:0]            imm_src_d,
   output logic                  illegal_d,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
   output logic                  alu_src_b_e,
   output logic                  alu_src_a_pc_e,
   output logic [1:0]            pc_src,
   output logic                  flush_o,
   output logic                  mem_write_m,
   output logic                  reg_write_m,
   output logic [1:0]            result_src_m,
   output logic                  reg_write_w,
   output logic [1:0]            result_src_w
`ifdef PL_CTRL_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_retired_o,
   output logic [PERF_CNT_W-1:0] perf_bubble_o,
   output logic [PERF_CNT_W-1:0] perf_taken_o
`endif
);

   import pl_ctrl_pkg::*;

   ctrl_bundle_t w_ctrl_d;
   ctrl_bundle_t w_ex_next;
   ctrl_bundle_t r_ex;

   logic       r_mem_valid;
   logic       r_mem_reg_write;
   logic       r_mem_mem_write;
   logic [1:0] r_mem_result_src;
   logic       r_wb_valid;
   logic       r_wb_reg_write;
   logic [1:0] r_wb_result_src;

   logic w_taken;
   logic w_jalr_res;
   logic w_kill_ex_mem;

   pl_ctrl_decoder u_dec (
      .i_opcode   (opcode_d),
      .i_funct3   (funct3_d),
      .i_funct7b5 (funct7b5_d),
      .o_ctrl     (w_ctrl_d),
      .o_imm_src  (imm_src_d),
      .o_illegal  (illegal_d)
   );

   // Flush and stall both yield the same all-zero bubble, so flush dominating stall is implicit.
   always_comb begin
      w_ex_next = w_ctrl_d;
      if (w_taken || flush_ext_i || stall_i) begin
         w_ex_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex <= '0;
      end else begin
         r_ex <= w_ex_next;
      end
   end

   generate
      if (BRANCH_IN_MEM == 0) begin : g_br_ex
         assign w_taken = r_ex.valid &
                          ((r_ex.branch & branch_cond(r_ex.funct3, zero_i, lt_i, ltu_i)) |
                           r_ex.jal | r_ex.jalr);
         assign w_jalr_res    = r_ex.jalr;
         assign w_kill_ex_mem = 1'b0;
      end else begin : g_br_mem
         logic       r_branch_m;
         logic       r_jal_m;
         logic       r_jalr_m;
         logic [2:0] r_funct3_m;
         logic       r_zero_m;
         logic       r_lt_m;
         logic       r_ltu_m;

         // Branch info and EX flags ride along into MEM so resolution is off the ALU path.
         always_ff @(posedge clk) begin
            if (rst || w_taken) begin
               r_branch_m <= 1'b0;
               r_jal_m    <= 1'b0;
               r_jalr_m   <= 1'b0;
               r_funct3_m <= 3'b000;
               r_zero_m   <= 1'b0;
               r_lt_m     <= 1'b0;
               r_ltu_m    <= 1'b0;
            end else begin
               r_branch_m <= r_ex.valid & r_ex.branch;
               r_jal_m    <= r_ex.valid & r_ex.jal;
               r_jalr_m   <= r_ex.valid & r_ex.jalr;
               r_funct3_m <= r_ex.funct3;
               r_zero_m   <= zero_i;
               r_lt_m     <= lt_i;
               r_ltu_m    <= ltu_i;
            end
         end

         assign w_taken = r_mem_valid &
                          ((r_branch_m & branch_cond(r_funct3_m, r_zero_m, r_lt_m, r_ltu_m)) |
                           r_jal_m | r_jalr_m);
         assign w_jalr_res    = r_jalr_m;
         assign w_kill_ex_mem = w_taken;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || w_kill_ex_mem) begin
         r_mem_valid      <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_result_src <= RES_ALU;
      end else begin
         r_mem_valid      <= r_ex.valid;
         r_mem_reg_write  <= r_ex.valid & r_ex.reg_write;
         r_mem_mem_write  <= r_ex.valid & r_ex.mem_write;
         r_mem_result_src <= r_ex.valid ? r_ex.result_src : RES_ALU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_valid      <= 1'b0;
         r_wb_reg_write  <= 1'b0;
         r_wb_result_src <= RES_ALU;
      end else begin
         r_wb_valid      <= r_mem_valid;
         r_wb_reg_write  <= r_mem_reg_write;
         r_wb_result_src <= r_mem_result_src;
      end
   end

   assign alu_ctrl_e     = r_ex.valid ? ALU_CTRL_W'(r_ex.alu_ctrl) : '0;
   assign alu_src_b_e    = r_ex.valid & r_ex.alu_src_b;
   assign alu_src_a_pc_e = r_ex.valid & r_ex.alu_src_a_pc;
   assign pc_src         = w_taken ? (w_jalr_res ? 2'b10 : 2'b01) : 2'b00;
   assign flush_o        = w_taken;
   assign mem_write_m    = r_mem_valid & r_mem_mem_write;
   assign reg_write_m    = r_mem_valid & r_mem_reg_write;
   assign result_src_m   = r_mem_result_src;
   assign reg_write_w    = r_wb_valid & r_wb_reg_write;
   assign result_src_w   = r_wb_result_src;

`ifdef PL_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] r_perf_retired;
   logic [PERF_CNT_W-1:0] r_perf_bubble;
   logic [PERF_CNT_W-1:0] r_perf_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_retired <= '0;
         r_perf_bubble  <= '0;
         r_perf_taken   <= '0;
      end else begin
         if (r_wb_valid) begin
            r_perf_retired <= r_perf_retired + 1'b1;
         end
         if (!w_ex_next.valid) begin
            r_perf_bubble <= r_perf_bubble + 1'b1;
         end
         if (w_taken) begin
            r_perf_taken <= r_perf_taken + 1'b1;
         end
      end
   end

   assign perf_retired_o = r_perf_retired;
   assign perf_bubble_o  = r_perf_bubble;
   assign perf_taken_o   = r_perf_taken;
`endif

endmodule
